toccata_playback: RTL
=====================

// Module: toccata_playback
// PURPOSE
//  Drains the Toccata sample FIFO at the programmed sample rate and assembles raw bytes into
//  signed left/right PCM frames for the DAC serializer. Sits directly after the sample FIFO;
//  one frame is fetched per sample_tick. Handles 8/16-bit, mono/stereo formats and underruns.
// PARAMETERS
//  SAMPLE_WIDTH   16  output sample width per channel; fixed 16, other values illegal
//  UCNT_WIDTH     16  width of underrun counter (only with TOCCATA_PB_UCNT_EN)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  enable       in   1   playback enable, sampled on sample_tick only
//  fmt_16bit    in   1   1: 16-bit big-endian samples, 0: 8-bit signed
//  fmt_stereo   in   1   1: stereo L-then-R, 0: mono
//  sample_tick  in   1   one-cycle pulse at the sample rate (from rate divider)
//  fifo_empty   in   1   FIFO empty flag
//  fifo_data    in   8   FIFO read data, valid 1 cycle after fifo_rd
//  fifo_rd      out  1   FIFO read strobe, one cycle per byte
//  left_out     out  16  signed left sample
//  right_out    out  16  signed right sample
//  out_valid    out  1   one-cycle pulse: new frame on left_out/right_out
//  busy         out  1   frame fetch in progress
//  underrun     out  1   one-cycle pulse: FIFO empty during a fetch
//  ucnt         out  UCNT_WIDTH  saturating underrun count (only with TOCCATA_PB_UCNT_EN)
// BEHAVIOUR
//  Reset: fifo_rd/out_valid/busy/underrun=0, left_out=right_out=0, ucnt=0, state IDLE.
//  Frame bytes N: 8b mono=1, 8b stereo=2, 16b mono=2, 16b stereo=4. fmt_* latched at frame start.
//  FSM: IDLE -> REQ on sample_tick && enable (latch fmt, byte idx=0); ticks with !enable ignored.
//   REQ: if fifo_empty -> UNDER; else fifo_rd=1 for exactly this cycle -> WAIT.
//   WAIT: one cycle (read latency) -> CAP.
//   CAP: store fifo_data in byte slot idx; idx==N-1 -> DONE, else idx++ -> REQ.
//   DONE: update outputs, out_valid=1 for one cycle -> IDLE.
//   UNDER: left_out=right_out=0, underrun=1 and out_valid=1 for one cycle; bytes already read
//    for the partial frame are discarded -> IDLE. No resync attempt.
//  busy=1 in every state except IDLE. Max fetch = 3*N+1 cycles (13 for 16b stereo).
//  sample_tick while busy: ignored, no queueing; tick period must exceed 13 cycles.
//  fifo_rd never asserted while fifo_empty=1 (sampled in REQ).
//  Assembly: 8b byte b -> {b,8'h00}; 16b -> {byte0,byte1} (MSB first). Stereo: first sample L,
//   second R. Mono: same sample on both channels. left_out/right_out update together, hold
//   value between frames.
//  enable deassert mid-frame: current frame completes normally; next tick ignored.
//  rst mid-frame: immediate return to IDLE, outputs zeroed, partial frame dropped.
// CONFIGURATION
//  TOCCATA_PB_UCNT_EN defined: ucnt port present; increments on each underrun pulse,
//   saturates at all-ones, cleared only by rst.
//  Not defined: ucnt port and counter absent; underrun pulse behaviour unchanged.
// TESTING
//  8b mono, FIFO holds 8'h80, tick -> one fifo_rd, out_valid 4 cycles after tick, L=R=16'h8000.
//  16b stereo, bytes 12 34 AB CD, tick -> 4 fifo_rd, L=16'h1234, R=16'hABCD, busy 13 cycles.
//  8b stereo, FIFO holds only 1 byte 7F -> underrun=1, out_valid=1, L=R=0, ucnt=1 (if _EN).
//  Tick with enable=0 or second tick during busy -> no fifo_rd, no out_valid, outputs held.
//  rst asserted during WAIT of 16b stereo frame -> next cycle IDLE, L=R=0, no out_valid.
//  With _EN, UCNT_WIDTH=2, 5 underruns -> ucnt saturates at 2'b11.

Source files
------------

// File: rtl/toccata_playback.sv
// toccata_playback: drains the Toccata sample FIFO once per sample_tick and
// assembles the fetched bytes into signed left/right PCM frames.
// Supported formats: 8-bit or 16-bit (big-endian) samples, mono or stereo.
// An empty FIFO during a fetch ends the frame as an underrun with silent output.
// Optional feature macro: TOCCATA_PB_UCNT_EN adds the saturating underrun
// counter output ucnt (width UCNT_WIDTH).
module toccata_playback #(
  parameter int SAMPLE_WIDTH = 16  // must remain 16; assembly is built for 16-bit samples
`ifdef TOCCATA_PB_UCNT_EN
  , parameter int UCNT_WIDTH = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    fmt_16bit,
  input  logic                    fmt_stereo,
  input  logic                    sample_tick,
  input  logic                    fifo_empty,
  input  logic [7:0]              fifo_data,
  output logic                    fifo_rd,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    underrun
`ifdef TOCCATA_PB_UCNT_EN
  , output logic [UCNT_WIDTH-1:0] ucnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAP,
    DONE,
    UNDER
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic        fmt16_reg, fmt16_next;
  logic        stereo_reg, stereo_next;
  logic [1:0]  last_idx;
  logic        frame_last;
  logic [7:0]  bytes_reg [0:3];
  logic [7:0]  byte_view [0:3];
  logic [15:0] asm_left;
  logic [15:0] asm_right;
  logic [SAMPLE_WIDTH-1:0] left_reg, right_reg;

  // Index of the final byte of a frame: 1, 2, 2 or 4 bytes per format.
  assign last_idx   = fmt16_reg ? (stereo_reg ? 2'd3 : 2'd1) : (stereo_reg ? 2'd1 : 2'd0);
  assign frame_last = (state_reg == CAP) && (idx_reg == last_idx);

  // Byte slots: each slot captures FIFO data in CAP when it is the addressed slot.
  // byte_view forwards the byte being captured so the frame can be assembled in
  // the same cycle its final byte arrives.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      // Capture the FIFO byte into this slot during its CAP cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          bytes_reg[gi] <= 8'h00;
        end else if ((state_reg == CAP) && (idx_reg == 2'(gi))) begin
          bytes_reg[gi] <= fifo_data;
        end
      end

      assign byte_view[gi] = ((state_reg == CAP) && (idx_reg == 2'(gi))) ? fifo_data
                                                                         : bytes_reg[gi];
    end
  endgenerate

  // Map frame bytes to left/right samples according to the latched format.
  always_comb begin
    asm_left  = 16'h0000;
    asm_right = 16'h0000;
    case ({fmt16_reg, stereo_reg})
      2'b00: begin
        asm_left  = {byte_view[0], 8'h00};
        asm_right = {byte_view[0], 8'h00};
      end
      2'b01: begin
        asm_left  = {byte_view[0], 8'h00};
        asm_right = {byte_view[1], 8'h00};
      end
      2'b10: begin
        asm_left  = {byte_view[0], byte_view[1]};
        asm_right = {byte_view[0], byte_view[1]};
      end
      default: begin
        asm_left  = {byte_view[0], byte_view[1]};
        asm_right = {byte_view[2], byte_view[3]};
      end
    endcase
  end

  // FSM state, byte index and latched format registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 2'd0;
      fmt16_reg  <= 1'b0;
      stereo_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      fmt16_reg  <= fmt16_next;
      stereo_reg <= stereo_next;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    fmt16_next  = fmt16_reg;
    stereo_next = stereo_reg;
    fifo_rd     = 1'b0;
    out_valid   = 1'b0;
    underrun    = 1'b0;
    busy        = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (sample_tick && enable) begin
          state_next  = REQ;
          idx_next    = 2'd0;
          fmt16_next  = fmt_16bit;
          stereo_next = fmt_stereo;
        end
      end
      REQ: begin
        if (fifo_empty) begin
          state_next = UNDER;
        end else begin
          fifo_rd    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        state_next = CAP;
      end
      CAP: begin
        if (frame_last) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 2'd1;
          state_next = REQ;
        end
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = IDLE;
      end
      UNDER: begin
        out_valid  = 1'b1;
        underrun   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output sample registers: loaded as DONE is entered, silenced as UNDER is entered,
  // otherwise held between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      left_reg  <= '0;
      right_reg <= '0;
    end else if ((state_reg == REQ) && fifo_empty) begin
      left_reg  <= '0;
      right_reg <= '0;
    end else if (frame_last) begin
      left_reg  <= asm_left;
      right_reg <= asm_right;
    end
  end

  assign left_out  = left_reg;
  assign right_out = right_reg;

`ifdef TOCCATA_PB_UCNT_EN
  logic [UCNT_WIDTH-1:0] ucnt_reg;

  // Saturating count of underrun pulses; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_reg <= '0;
    end else if ((state_reg == UNDER) && (ucnt_reg != {UCNT_WIDTH{1'b1}})) begin
      ucnt_reg <= ucnt_reg + 1'b1;
    end
  end

  assign ucnt = ucnt_reg;
`endif

endmodule
